uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver: the next generation of the team's fixed 8N1 receiver. Data width, parity mode, stop-bit count and oversample ratio are configurable. Each sample point uses a 3-sample majority vote. False-start rejection, parity/framing/overrun reporting and a valid/ready output handshake are added. It sits between a pad-level RX line and a bus-side FIFO or CSR block, with the baud rate set at run time through a divisor input.

---
 rtl/uart_rx_os_if.sv | 36 +++
 rtl/uart_rx_os.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// ---------------------------------------------------------------------------
// uart_rx_os_if
//   Output-side handshake bundle of the oversampling UART receiver.
//   Signal names are seen from the receiver: the *_o signals are driven by
//   the receiver, ready_i is driven by the consumer (FIFO / CSR block).
//
//   data_o       : received word (DATA_BITS wide, LSB = first bit on the line)
//   valid_o      : data_o and the error flags are valid
//   ready_i      : consumer takes the word on a clock with valid_o && ready_i
//   parity_err_o : parity mismatch for the held word
//   frame_err_o  : a stop bit was sampled low for the held word
//   overrun_o    : one-clock pulse, a frame was dropped because valid_o was high
//
//   master : the receiver
//   slave  : the consumer
// ---------------------------------------------------------------------------
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 overrun_o;

  modport master (
    output data_o, valid_o, parity_err_o, frame_err_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o, valid_o, parity_err_o, frame_err_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
//   Parametrised oversampling UART receiver. The line is synchronised, a
//   run-time prescaler produces OVERSAMPLE ticks per bit, and every bit is
//   decided by a 3-sample majority vote around the middle of the bit.
//   Completed words are offered on a valid/ready handshake together with
//   parity and framing flags; a frame that completes while the previous word
//   is still held is dropped and reported with a one-clock overrun pulse.
//
//   Parameters: DATA_BITS (5..9), PARITY (0 none, 1 odd, 2 even),
//               STOP_BITS (1 or 2), OVERSAMPLE (power of two, 8..64),
//               DIV_W (width of compare_i)
//
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   rx_i      : asynchronous serial line, idle high
//   compare_i : oversample tick period minus one, in clocks
//   busy_o    : receiver is not idle
//   rx_if     : output handshake (data, valid/ready, error flags, overrun)
// ---------------------------------------------------------------------------
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] compare_i,
  output logic             busy_o,
  uart_rx_os_if.master     rx_if
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);

  // Phase values of the three vote samples and of the bit boundary.
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_S2   = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

  // Odd parity expects (parity bit ^ data parity) = 1, even expects 0.
  localparam logic PAR_EXP = (PARITY == 1) ? 1'b1 : 1'b0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BRK   = 3'd5;

  // Synchroniser; rx_s_q is the only view of the line used below.
  logic                 rx_meta_q, rx_s_q;

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     pre_q, pre_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [1:0]           samp_q, samp_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pend_pe_q, pend_pe_d;   // parity result of the frame in flight
  logic                 pend_fe_q, pend_fe_d;   // any low stop bit so far in this frame

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  logic tick, sample_pt, boundary, vote, stop_last, handshake;
  logic deliver, deliver_fe;

  assign tick      = (state_q != ST_IDLE) && (pre_q == div_q);
  assign sample_pt = tick && (ph_q == PH_S2);
  assign boundary  = tick && (ph_q == PH_LAST);
  // Majority of the two stored samples and the current one.
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign stop_last = (STOP_BITS == 1) || stop_q;
  assign handshake = valid_q && rx_if.ready_i;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    div_d      = div_q;
    ph_d       = ph_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    pend_pe_d  = pend_pe_q;
    pend_fe_d  = pend_fe_q;
    data_d     = data_q;
    valid_d    = valid_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    ov_d       = 1'b0;
    deliver    = 1'b0;
    deliver_fe = pend_fe_q;

    pre_d = (state_q == ST_IDLE || tick) ? '0 : pre_q + DIV_W'(1);

    if (tick) begin
      ph_d = ph_q + PH_W'(1);   // power-of-two width wraps at OVERSAMPLE
      if (ph_q == PH_S0) samp_d[0] = rx_s_q;
      if (ph_q == PH_S1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          div_d     = compare_i;
          ph_d      = '0;
          bit_d     = '0;
          stop_d    = 1'b0;
          pend_pe_d = 1'b0;
          pend_fe_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (sample_pt && vote) begin
          state_d = ST_IDLE;          // false start, nothing reported
        end else if (boundary) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_pt) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (boundary) begin
          if (bit_q == BIT_LAST) begin
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (sample_pt) pend_pe_d = ((vote ^ (^shift_q)) != PAR_EXP);
        if (boundary)  state_d   = ST_STOP;
      end
      ST_STOP: begin
        if (sample_pt) begin
          if (!vote) pend_fe_d = 1'b1;
          if (stop_last) begin
            // The frame ends at the last stop sample point, half a bit early,
            // so a following start edge is never missed.
            deliver    = 1'b1;
            deliver_fe = pend_fe_q | ~vote;
            state_d    = vote ? ST_IDLE : ST_BRK;
          end
        end
        if (boundary) stop_d = 1'b1;
      end
      ST_BRK: begin
        // Stay here while the line is low so a break cannot look like frames.
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (deliver) begin
      if (!valid_q || handshake) begin
        data_d  = shift_q;
        pe_d    = pend_pe_q;
        fe_d    = deliver_fe;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;                  // held word wins, new frame is dropped
      end
    end else if (handshake) begin
      valid_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      div_q     <= '0;
      pre_q     <= '0;
      ph_q      <= '0;
      samp_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      pend_pe_q <= 1'b0;
      pend_fe_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      pre_q     <= pre_d;
      ph_q      <= ph_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      pend_pe_q <= pend_pe_d;
      pend_fe_q <= pend_fe_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign busy_o             = (state_q != ST_IDLE);
  assign rx_if.data_o       = data_q;
  assign rx_if.valid_o      = valid_q;
  assign rx_if.parity_err_o = pe_q;
  assign rx_if.frame_err_o  = fe_q;
  assign rx_if.overrun_o    = ov_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os
//   Three receivers share clock, reset and divisor (compare = 3, 64 clocks
//   per bit), each with its own line:
//     dut 0 (a): 8N1 defaults
//     dut 1 (b): 7 data bits, even parity, 1 stop
//     dut 2 (c): 8 data bits, no parity, 2 stop bits
//   Inputs change 1 time unit after a rising edge; outputs are read there or
//   on the falling edge by the monitor.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_a, rx_b, rx_c;
  logic [15:0] compare;
  logic        busy_a, busy_b, busy_c;

  uart_rx_os_if #(.DATA_BITS(8)) if_a ();
  uart_rx_os_if #(.DATA_BITS(7)) if_b ();
  uart_rx_os_if #(.DATA_BITS(8)) if_c ();

  uart_rx_os dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .compare_i(compare),
    .busy_o(busy_a), .rx_if(if_a)
  );
  uart_rx_os #(.DATA_BITS(7), .PARITY(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .compare_i(compare),
    .busy_o(busy_b), .rx_if(if_b)
  );
  uart_rx_os #(.STOP_BITS(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_c), .compare_i(compare),
    .busy_o(busy_c), .rx_if(if_c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- accessors -------------------------------------------
  function automatic logic [8:0] f_data(input int d);
    case (d)
      0:       return {1'b0, if_a.data_o};
      1:       return {2'b0, if_b.data_o};
      default: return {1'b0, if_c.data_o};
    endcase
  endfunction
  function automatic logic f_valid(input int d);
    case (d) 0: return if_a.valid_o; 1: return if_b.valid_o; default: return if_c.valid_o; endcase
  endfunction
  function automatic logic f_ready(input int d);
    case (d) 0: return if_a.ready_i; 1: return if_b.ready_i; default: return if_c.ready_i; endcase
  endfunction
  function automatic logic f_pe(input int d);
    case (d) 0: return if_a.parity_err_o; 1: return if_b.parity_err_o; default: return if_c.parity_err_o; endcase
  endfunction
  function automatic logic f_fe(input int d);
    case (d) 0: return if_a.frame_err_o; 1: return if_b.frame_err_o; default: return if_c.frame_err_o; endcase
  endfunction
  function automatic logic f_ov(input int d);
    case (d) 0: return if_a.overrun_o; 1: return if_b.overrun_o; default: return if_c.overrun_o; endcase
  endfunction
  function automatic logic f_busy(input int d);
    case (d) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction

  // ---------------- monitor (falling edge) -------------------------------
  int         rise_cnt [3] = '{0, 0, 0};
  int         ov_cnt   [3] = '{0, 0, 0};
  int         acc_cnt  [3] = '{0, 0, 0};
  logic       vprev    [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] acc_words[3][16];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (f_ov(d)) ov_cnt[d]++;
      if (f_valid(d) && !vprev[d]) rise_cnt[d]++;
      if (f_valid(d) && f_ready(d)) begin
        acc_words[d][acc_cnt[d] % 16] = f_data(d);
        acc_cnt[d]++;
      end
      vprev[d] = f_valid(d);
    end
  end

  // ---------------- helpers ---------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d) 0: rx_a = v; 1: rx_b = v; default: rx_c = v; endcase
  endtask

  task automatic set_ready(input int d, input logic v);
    case (d) 0: if_a.ready_i = v; 1: if_b.ready_i = v; default: if_c.ready_i = v; endcase
  endtask

  // Frame layout follows the dut: b has 7 data bits plus parity, c has two
  // stop bits (stop[0] first, stop[1] second).
  task automatic send_frame(input int d, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stop);
    logic [15:0] bits;
    int          n;
    int          nd;
    nd   = (d == 1) ? 7 : 8;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (d == 1) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop[0];
    n++;
    if (d == 2) begin
      bits[n] = stop[1];
      n++;
    end
    for (int i = 0; i < n; i++) begin
      set_rx(d, bits[i]);
      clks(BIT_CLKS);
    end
  endtask

  task automatic check_word(input string tag, input int d, input logic [8:0] exp_data,
                            input logic exp_pe, input logic exp_fe);
    check({tag, ".valid"}, 32'(f_valid(d)), 32'd1);
    check({tag, ".data"},  32'(f_data(d)),  32'(exp_data));
    check({tag, ".perr"},  32'(f_pe(d)),    32'(exp_pe));
    check({tag, ".ferr"},  32'(f_fe(d)),    32'(exp_fe));
  endtask

  task automatic ack(input string tag, input int d);
    set_ready(d, 1'b1);
    clks(1);
    set_ready(d, 1'b0);
    check({tag, ".ack_clears_valid"}, 32'(f_valid(d)), 32'd0);
    check({tag, ".ack_clears_ferr"},  32'(f_fe(d)),    32'd0);
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       par;
    logic [1:0] stop;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  initial begin
    int r0, o0, a0;

    vecs[0]  = '{0, 9'h000, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h0FF, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h05A, 1'b0, 2'b10, 1'b0, 1'b1};  // stop bit low
    vecs[3]  = '{1, 9'h055, 1'b1, 2'b11, 1'b1, 1'b0};  // 4 ones, bit 1: even parity wrong
    vecs[4]  = '{1, 9'h055, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[5]  = '{1, 9'h007, 1'b1, 2'b11, 1'b0, 1'b0};  // 3 ones, bit 1: correct
    vecs[6]  = '{1, 9'h07F, 1'b0, 2'b11, 1'b1, 1'b0};  // 7 ones, bit 0: wrong
    vecs[7]  = '{1, 9'h02A, 1'b1, 2'b10, 1'b0, 1'b1};  // parity ok, stop low
    vecs[8]  = '{2, 9'h081, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h03C, 1'b0, 2'b10, 1'b0, 1'b1};  // first stop low
    vecs[10] = '{2, 9'h0C3, 1'b0, 2'b01, 1'b0, 1'b1};  // second stop low

    rst_n   = 1'b0;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    rx_c    = 1'b1;
    compare = 16'd3;
    if_a.ready_i = 1'b0;
    if_b.ready_i = 1'b0;
    if_c.ready_i = 1'b0;
    clks(3);

    // Reset state.
    for (int d = 0; d < 3; d++) begin
      check("reset.valid", 32'(f_valid(d)), 32'd0);
      check("reset.data",  32'(f_data(d)),  32'd0);
      check("reset.perr",  32'(f_pe(d)),    32'd0);
      check("reset.ferr",  32'(f_fe(d)),    32'd0);
      check("reset.ovr",   32'(f_ov(d)),    32'd0);
      check("reset.busy",  32'(f_busy(d)),  32'd0);
    end
    rst_n = 1'b1;
    clks(10);

    // Case 1: 0xA5 8N1, word held until ready.
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    check_word("c1", 0, 9'h0A5, 1'b0, 1'b0);
    check("c1.busy_after", 32'(busy_a), 32'd0);
    clks(100);
    check("c1.hold_valid", 32'(f_valid(0)), 32'd1);
    check("c1.hold_data",  32'(f_data(0)),  32'h0A5);
    ack("c1", 0);
    clks(BIT_CLKS);

    // Table: formats, parity and framing variants.
    for (int v = 0; v < NVEC; v++) begin
      send_frame(vecs[v].dut, vecs[v].data, vecs[v].par, vecs[v].stop);
      check_word($sformatf("vec%0d", v), vecs[v].dut, vecs[v].data, vecs[v].exp_pe, vecs[v].exp_fe);
      set_rx(vecs[v].dut, 1'b1);
      ack($sformatf("vec%0d", v), vecs[v].dut);
      clks(BIT_CLKS);
      check($sformatf("vec%0d.idle", v), 32'(f_busy(vecs[v].dut)), 32'd0);
    end

    // Case 3: break. One word with frame error, no retrigger while low.
    send_frame(0, 9'h000, 1'b0, 2'b00);
    check_word("c3", 0, 9'h000, 1'b0, 1'b1);
    ack("c3", 0);
    r0 = rise_cnt[0];
    clks(20 * BIT_CLKS);
    check("c3.no_retrigger", 32'(rise_cnt[0] - r0), 32'd0);
    check("c3.brk_busy",     32'(busy_a),           32'd1);
    set_rx(0, 1'b1);
    clks(BIT_CLKS);
    check("c3.brk_exit", 32'(busy_a), 32'd0);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    check_word("c3.after", 0, 9'h03C, 1'b0, 1'b0);
    ack("c3.after", 0);
    clks(BIT_CLKS);

    // Case 4a: 2-tick low glitch is a false start.
    r0 = rise_cnt[0];
    set_rx(0, 1'b0);
    clks(5);
    check("c4.glitch_busy", 32'(busy_a), 32'd1);
    clks(3);
    set_rx(0, 1'b1);
    clks(2 * BIT_CLKS);
    check("c4.glitch_idle",  32'(busy_a),           32'd0);
    check("c4.glitch_noval", 32'(rise_cnt[0] - r0), 32'd0);

    // Case 4b: 0xF0 with a one-tick inverted spike on the middle vote sample.
    set_rx(0, 1'b0);
    clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'hF0;
      set_rx(0, w[i]);
      clks(36);
      set_rx(0, ~w[i]);
      clks(4);
      set_rx(0, w[i]);
      clks(24);
    end
    set_rx(0, 1'b1);
    clks(BIT_CLKS);
    check_word("c4.spike", 0, 9'h0F0, 1'b0, 1'b0);
    ack("c4.spike", 0);
    clks(BIT_CLKS);

    // Case 5a: overrun with ready low.
    o0 = ov_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11);
    clks(BIT_CLKS);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    clks(BIT_CLKS);
    check_word("c5.ovr", 0, 9'h011, 1'b0, 1'b0);
    check("c5.ovr_pulses", 32'(ov_cnt[0] - o0), 32'd1);
    check("c5.ovr_low",    32'(f_ov(0)),        32'd0);
    ack("c5.ovr", 0);
    clks(BIT_CLKS);

    // Case 5b: ready tied high, two deliveries and no overrun.
    set_ready(0, 1'b1);
    o0 = ov_cnt[0];
    a0 = acc_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11);
    clks(BIT_CLKS);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    clks(BIT_CLKS);
    set_ready(0, 1'b0);
    check("c5.accepted", 32'(acc_cnt[0] - a0),         32'd2);
    check("c5.word0",    32'(acc_words[0][a0 % 16]),   32'h011);
    check("c5.word1",    32'(acc_words[0][(a0 + 1) % 16]), 32'h022);
    check("c5.no_ovr",   32'(ov_cnt[0] - o0),          32'd0);
    check("c5.valid_lo", 32'(f_valid(0)),              32'd0);
    clks(BIT_CLKS);

    // Case 6: reset at mid bit 4 with a word still held, then 0x81 8N2.
    send_frame(2, 9'h05A, 1'b0, 2'b11);
    check_word("c6.held", 2, 9'h05A, 1'b0, 1'b0);
    set_rx(2, 1'b0);
    clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      w = 8'h81;
      set_rx(2, w[i]);
      clks(BIT_CLKS);
    end
    set_rx(2, 1'b0);
    clks(BIT_CLKS / 2);
    check("c6.busy_mid", 32'(busy_c), 32'd1);
    rst_n = 1'b0;
    #1;
    check("c6.rst_valid", 32'(f_valid(2)), 32'd0);
    check("c6.rst_data",  32'(f_data(2)),  32'd0);
    check("c6.rst_perr",  32'(f_pe(2)),    32'd0);
    check("c6.rst_ferr",  32'(f_fe(2)),    32'd0);
    check("c6.rst_ovr",   32'(f_ov(2)),    32'd0);
    check("c6.rst_busy",  32'(busy_c),     32'd0);
    clks(2);
    set_rx(2, 1'b1);
    rst_n = 1'b1;
    clks(BIT_CLKS);
    check("c6.idle_after", 32'(busy_c), 32'd0);
    send_frame(2, 9'h081, 1'b0, 2'b11);
    check_word("c6", 2, 9'h081, 1'b0, 1'b0);
    ack("c6", 2);
    clks(BIT_CLKS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
